interrupt_request_controller: RTL

- Initiator side of the CPU interrupt handshake. Collects edge-triggered interrupt requests from up to N_SRC peripherals (neuromorphic cores, timers) and masks them.
- Picks one request by fixed priority and drives the single interrupt_signal line into the CPU's interrupt control unit.
- Tracks the CPU acknowledge (PC-save write) and the ISR return (jalr through x30), so only one interrupt is ever in service.

---
 rtl/interrupt_request_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/interrupt_request_controller.sv
// Fixed-priority interrupt initiator: synchronises and edge-detects peripheral requests,
// raises interrupt_signal to the CPU and tracks acknowledge / ISR return so one interrupt is in service.
module interrupt_request_controller #(
  parameter int N_SRC       = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              mask_we,
  input  logic [N_SRC-1:0]  mask_wdata,
  input  logic              isr_ack,
  input  logic              jalr_select_signal,
  input  logic [4:0]        regfile_adrr_1,
  output logic              interrupt_signal,
  output logic [ID_W-1:0]   active_id,
  output logic              in_service,
  output logic [N_SRC-1:0]  pending,
  output logic              ack_timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQUEST, IN_SERVICE} state_t;

  state_t             r_state, w_state_nxt;
  logic [N_SRC-1:0]   r_s1, r_s2, r_s3;
  logic [1:0]         r_warm;
  logic [N_SRC-1:0]   r_pending, r_mask;
  logic               r_irq, r_in_service, r_ack_timeout;
  logic [ID_W-1:0]    r_active_id;
  logic [CNT_W-1:0]   r_cnt;

  logic [N_SRC-1:0]   w_edge, w_eligible, w_clr;
  logic [ID_W-1:0]    w_winner, w_active_id_nxt;
  logic               w_isr_return, w_irq_nxt, w_in_service_nxt, w_ack_timeout_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Edges are suppressed until s3 holds a real post-reset sample, so lines already high at reset are ignored.
  assign w_edge       = (r_warm == 2'd3) ? (r_s2 & ~r_s3) : '0;
  assign w_eligible   = r_pending & r_mask;
  assign w_isr_return = jalr_select_signal && (regfile_adrr_1 == 5'd30);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_warm <= 2'd0;
    end else begin
      r_s1   <= irq_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_warm <= (r_warm == 2'd3) ? r_warm : r_warm + 2'd1;
    end
  end

  // A new edge on the source being acknowledged overrides its clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
      r_mask    <= '1;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  always_comb begin
    w_winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = ID_W'(i);
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_irq_nxt         = 1'b0;
    w_in_service_nxt  = 1'b0;
    w_ack_timeout_nxt = 1'b0;
    w_active_id_nxt   = r_active_id;
    w_cnt_nxt         = r_cnt;
    w_clr             = '0;
    case (r_state)
      IDLE: begin
        if (|w_eligible) begin
          w_state_nxt     = REQUEST;
          w_irq_nxt       = 1'b1;
          w_active_id_nxt = w_winner;
          w_cnt_nxt       = '0;
        end
      end
      REQUEST: begin
        if (isr_ack) begin
          w_clr            = N_SRC'(1) << r_active_id;
          w_in_service_nxt = 1'b1;
          w_state_nxt      = IN_SERVICE;
        end else if (r_cnt == CNT_LAST) begin
          w_ack_timeout_nxt = 1'b1;
          w_state_nxt       = IDLE;
        end else begin
          w_irq_nxt = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      IN_SERVICE: begin
        if (w_isr_return) w_state_nxt = IDLE;
        else              w_in_service_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_irq         <= 1'b0;
      r_in_service  <= 1'b0;
      r_ack_timeout <= 1'b0;
      r_active_id   <= '0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_irq         <= w_irq_nxt;
      r_in_service  <= w_in_service_nxt;
      r_ack_timeout <= w_ack_timeout_nxt;
      r_active_id   <= w_active_id_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign interrupt_signal = r_irq;
  assign active_id        = r_active_id;
  assign in_service       = r_in_service;
  assign pending          = r_pending;
  assign ack_timeout      = r_ack_timeout;

endmodule
